// File: rtl/store_pkg.sv
// store_pkg: shared constants, FSM encoding and the funct3-to-byte-mask helper
// for the store path.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBeat0 = 2'd1,
        StBeat1 = 2'd2
    } state_e;

    // An empty mask marks an illegal funct3.
    function automatic logic [3:0] f3_mask(logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_SB:   m = MASK_B;
            F3_SH:   m = MASK_H;
            F3_SW:   m = MASK_W;
            default: m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// store_unit_if: request handshake from execute plus the memory write-beat
// channel. The master modport is the side driving requests and mem_ready.
interface store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        done;
    logic        err;

    modport master (
        output req_valid, req_funct3, req_addr, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );

endinterface

// File: rtl/store_lane_align.sv
// store_lane_align: combinational steering of rs2 onto a two-word lane window.
// The low word feeds beat 0, the high word feeds beat 1.
module store_lane_align
    import store_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [63:0] wide,
    output logic [7:0]  strb8,
    output logic        split,
    output logic        legal
);

    logic [3:0] mask;

    // Shift mask and data by the byte offset into the 64-bit window.
    always_comb begin
        mask  = f3_mask(funct3);
        legal = (mask != MASK_NONE);
        strb8 = {4'b0000, mask} << off;
        wide  = {32'h0, data} << {off, 3'b000};
        split = |strb8[7:4];
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: accepts one SB/SH/SW request and issues one (or, with
// STORE_SPLIT_EN defined, two) lane-steered memory write beats.
// Without STORE_SPLIT_EN only naturally aligned stores are executed.
module store_unit
    import store_pkg::*;
(
    input logic         clk,
    input logic         reset,
    store_unit_if.slave bus
);

    state_e      state;
    logic [63:0] wide;
    logic [7:0]  strb8;
    logic        split;
    logic        legal;
    logic        reject;

    store_lane_align u_align (
        .funct3 (bus.req_funct3),
        .off    (bus.req_addr[1:0]),
        .data   (bus.req_data),
        .wide   (wide),
        .strb8  (strb8),
        .split  (split),
        .legal  (legal)
    );

`ifdef STORE_SPLIT_EN
    logic [31:0] hi_data;
    logic [3:0]  hi_strb;
    logic        need_split;

    // Rejection: only an illegal funct3.
    always_comb reject = !legal;
`else
    logic unused_hi;

    // High half of the window never reaches memory in this build.
    always_comb unused_hi = ^{wide[63:32], strb8[7:4]};

    // Rejection: illegal funct3, word crossing, or SH at an odd address.
    always_comb reject = !legal || split ||
                         ((bus.req_funct3 == F3_SH) && bus.req_addr[0]);
`endif

    // FSM with registered handshake and memory outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            bus.req_ready <= 1'b1;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_wstrb <= 4'h0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
`ifdef STORE_SPLIT_EN
            hi_data       <= 32'h0;
            hi_strb       <= 4'h0;
            need_split    <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        if (reject) begin
                            bus.err <= 1'b1;
                        end else begin
                            state         <= StBeat0;
                            bus.req_ready <= 1'b0;
                            bus.mem_valid <= 1'b1;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wdata <= wide[31:0];
                            bus.mem_wstrb <= strb8[3:0];
`ifdef STORE_SPLIT_EN
                            hi_data       <= wide[63:32];
                            hi_strb       <= strb8[7:4];
                            need_split    <= split;
`endif
                        end
                    end
                end
                StBeat0: begin
                    if (bus.mem_ready) begin
`ifdef STORE_SPLIT_EN
                        if (need_split) begin
                            state         <= StBeat1;
                            bus.mem_addr  <= bus.mem_addr + 32'd4;
                            bus.mem_wdata <= hi_data;
                            bus.mem_wstrb <= hi_strb;
                        end else begin
                            state         <= StIdle;
                            bus.mem_valid <= 1'b0;
                            bus.req_ready <= 1'b1;
                            bus.done      <= 1'b1;
                        end
`else
                        state         <= StIdle;
                        bus.mem_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.done      <= 1'b1;
`endif
                    end
                end
`ifdef STORE_SPLIT_EN
                StBeat1: begin
                    if (bus.mem_ready) begin
                        state         <= StIdle;
                        bus.mem_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.done      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state         <= StIdle;
                    bus.mem_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed plus randomized stores checked against a byte-level
// reference model. Honours STORE_SPLIT_EN the same way as the design.
module tb_store_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    store_unit_if bus ();

    store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour of one store, derived byte by byte.
    task automatic model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         output bit rej, output int nb,
                         output logic [31:0] a0, output logic [31:0] a1,
                         output logic [31:0] w0, output logic [31:0] w1,
                         output logic [3:0] s0, output logic [3:0] s1);
        int size;
        int off;
        logic [63:0] win;
        off = int'(addr % 4);
        case (f3)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            default: size = 0;
        endcase
        s0 = 4'h0;
        s1 = 4'h0;
        for (int i = 0; i < size; i++) begin
            if (off + i < 4) s0[off + i] = 1'b1;
            else             s1[off + i - 4] = 1'b1;
        end
        win = {32'h0, data} << (8 * off);
        w0  = win[31:0];
        w1  = win[63:32];
        a0  = addr & ~32'h3;
        a1  = a0 + 32'd4;
        nb  = (off + size > 4) ? 2 : 1;
`ifdef STORE_SPLIT_EN
        rej = (size == 0);
`else
        rej = (size == 0) ? 1'b1 : ((off % size) != 0);
`endif
    endtask

    // Present one request at a negedge and follow it to done/err.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input int stall_lo, input int stall_hi);
        bit rej;
        int nb;
        int stall;
        logic [31:0] a0, a1, w0, w1;
        logic [3:0]  s0, s1;
        model(f3, addr, data, rej, nb, a0, a1, w0, w1, s0, s1);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_data   = data;
        bus.mem_ready  = 1'($urandom % 2);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_data   = $urandom;
        if (rej) begin
            check("err_pulse", bus.err, 1);
            check("err_no_beat", bus.mem_valid, 0);
            check("err_ready", bus.req_ready, 1);
            check("err_no_done", bus.done, 0);
            @(posedge clk);
            @(negedge clk);
            check("err_clear", bus.err, 0);
            check("err_no_beat2", bus.mem_valid, 0);
        end else begin
            for (int b = 0; b < nb; b++) begin
                stall = $urandom_range(stall_hi, stall_lo);
                bus.mem_ready = 1'b0;
                for (int k = 0; k <= stall; k++) begin
                    if (k == stall) bus.mem_ready = 1'b1;
                    check("beat_valid", bus.mem_valid, 1);
                    check("beat_addr", bus.mem_addr, (b == 0) ? a0 : a1);
                    check("beat_wdata", bus.mem_wdata, (b == 0) ? w0 : w1);
                    check("beat_wstrb", bus.mem_wstrb, (b == 0) ? s0 : s1);
                    check("beat_no_done", bus.done, 0);
                    check("beat_no_err", bus.err, 0);
                    check("beat_not_ready", bus.req_ready, 0);
                    // Requests during a store must be ignored.
                    bus.req_valid = 1'($urandom % 2);
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            bus.mem_ready = 1'b0;
            bus.req_valid = 1'b0;
            check("done_pulse", bus.done, 1);
            check("done_no_beat", bus.mem_valid, 0);
            check("done_ready", bus.req_ready, 1);
            check("done_no_err", bus.err, 0);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_data   = 32'h0;
        bus.mem_ready  = 1'b0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_wstrb", bus.mem_wstrb, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;

        // Directed cases.
        run_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);
        run_store(3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0);
        run_store(3'b001, 32'h0000_0302, 32'h0000_1234, 3, 3);
        run_store(3'b010, 32'h0000_03FF, 32'h1122_3344, 0, 1);
        run_store(3'b011, 32'h0000_0100, 32'h5555_5555, 0, 0);
        run_store(3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 0);
        run_store(3'b001, 32'h0000_0401, 32'h0000_ABCD, 0, 0);
        run_store(3'b001, 32'hFFFF_FFFF, 32'h0000_9876, 1, 1);
        run_store(3'b111, 32'h0000_0000, 32'h0000_0000, 0, 0);

        // Reset during a stalled first beat abandons the store.
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0100;
        bus.req_data   = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        check("stall_valid", bus.mem_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        check("mid_rst_valid", bus.mem_valid, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("mid_rst_valid2", bus.mem_valid, 0);
        check("mid_rst_done2", bus.done, 0);

        // Randomized stores, biased toward legal funct3 and the top word.
        repeat (300) begin
            f3   = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'($urandom);
            addr = ($urandom % 8 == 0) ? {30'h3FFF_FFFF, 2'($urandom)} : $urandom;
            run_store(f3, addr, $urandom, 0, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
